// File: rtl/jzjpcc_memory_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and load/store.
// Load/store wins ties, but a streak counter forces a fetch grant after MAX_LS_STREAK in a row.
module jzjpcc_memory_arbiter #(
  parameter int ADDR_WIDTH    = 12,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  output logic                  ifReady,
  output logic [31:0]           ifRdata,
  output logic                  ifRvalid,

  input  logic                  lsReq,
  input  logic                  lsWriteEn,
  input  logic [ADDR_WIDTH-1:0] lsAddr,
  input  logic [31:0]           lsWdata,
  input  logic [3:0]            lsByteMask,
  output logic                  lsReady,
  output logic [31:0]           lsRdata,
  output logic                  lsRvalid,

  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic                  memWriteEn,
  output logic [3:0]            memByteMask,
  input  logic [31:0]           memRdata
);

  localparam int STREAK_WIDTH = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(MAX_LS_STREAK);
  localparam logic [STREAK_WIDTH-1:0] STREAK_ONE = STREAK_WIDTH'(1);

  logic [STREAK_WIDTH-1:0] streak_q, streak_d;
  logic                    if_rvalid_q, if_rvalid_d;
  logic                    ls_rvalid_q, ls_rvalid_d;
  logic                    if_grant, ls_grant;

  // Grants are forced low while reset is held so nothing reaches the SRAM mid-reset.
  always_comb begin
    if_grant = 1'b0;
    ls_grant = 1'b0;
    if (!reset) begin
      if (lsReq && (!ifReq || (streak_q != STREAK_MAX))) begin
        ls_grant = 1'b1;
      end else if (ifReq) begin
        if_grant = 1'b1;
      end
    end
  end

  // The streak only counts load/store wins that made fetch wait.
  always_comb begin
    streak_d = '0;
    if (ls_grant && ifReq && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_ONE;
    end
  end

  always_comb begin
    memAddr     = '0;
    memWdata    = '0;
    memWriteEn  = 1'b0;
    memByteMask = '0;
    if (ls_grant) begin
      memAddr     = lsAddr;
      memWdata    = lsWdata;
      memWriteEn  = lsWriteEn;
      memByteMask = lsByteMask;
    end else if (if_grant) begin
      memAddr = ifAddr;
    end
  end

  // Stores are acknowledged by ready alone; only reads earn a response slot.
  always_comb begin
    if_rvalid_d = if_grant;
    ls_rvalid_d = ls_grant && !lsWriteEn;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
    end
  end

  assign ifReady  = if_grant;
  assign lsReady  = ls_grant;
  assign ifRvalid = if_rvalid_q;
  assign lsRvalid = ls_rvalid_q;
  assign ifRdata  = memRdata;
  assign lsRdata  = memRdata;

endmodule

// File: tb/tb_jzjpcc_memory_arbiter.sv
// Directed bench for jzjpcc_memory_arbiter with a byte-masked SRAM model
// and per-requester scoreboards of expected read data.
module tb_jzjpcc_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        ifReq;
  logic [11:0] ifAddr;
  logic        ifReady;
  logic [31:0] ifRdata;
  logic        ifRvalid;
  logic        lsReq;
  logic        lsWriteEn;
  logic [11:0] lsAddr;
  logic [31:0] lsWdata;
  logic [3:0]  lsByteMask;
  logic        lsReady;
  logic [31:0] lsRdata;
  logic        lsRvalid;
  logic [11:0] memAddr;
  logic [31:0] memWdata;
  logic        memWriteEn;
  logic [3:0]  memByteMask;
  logic [31:0] memRdata;

  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  logic [31:0] sram    [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] if_q [$];
  logic [31:0] ls_q [$];
  logic        exp_if_valid;
  logic        exp_ls_valid;
  int          compared;
  int          mismatched;

  jzjpcc_memory_arbiter #(.ADDR_WIDTH(12), .MAX_LS_STREAK(4)) dut (
    .clock(clock), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifReady(ifReady), .ifRdata(ifRdata), .ifRvalid(ifRvalid),
    .lsReq(lsReq), .lsWriteEn(lsWriteEn), .lsAddr(lsAddr), .lsWdata(lsWdata),
    .lsByteMask(lsByteMask), .lsReady(lsReady), .lsRdata(lsRdata), .lsRvalid(lsRvalid),
    .memAddr(memAddr), .memWdata(memWdata), .memWriteEn(memWriteEn),
    .memByteMask(memByteMask), .memRdata(memRdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM with one-cycle registered read and byte-masked writes.
  always @(posedge clock) begin
    if (pre_we) begin
      sram[pre_addr] <= pre_data;
    end else if (memWriteEn) begin
      for (int b = 0; b < 4; b++) begin
        if (memByteMask[b]) sram[memAddr][8*b +: 8] <= memWdata[8*b +: 8];
      end
    end
    memRdata <= sram[memAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic i_req, input logic [11:0] i_addr,
                               input logic l_req, input logic l_we, input logic [11:0] l_addr,
                               input logic [31:0] l_wdata, input logic [3:0] l_mask);
    ifReq      = i_req;
    ifAddr     = i_addr;
    lsReq      = l_req;
    lsWriteEn  = l_we;
    lsAddr     = l_addr;
    lsWdata    = l_wdata;
    lsByteMask = l_mask;
  endtask

  // One clock: check responses owed from the previous grant, check this grant, book the next responses.
  task automatic runCycle(input string tag, input logic exp_if, input logic exp_ls);
    logic [31:0] d;
    @(negedge clock);
    checkOutput({tag, "_ifRvalid"}, 32'(ifRvalid), 32'(exp_if_valid));
    if (exp_if_valid) begin
      if (if_q.size() == 0) checkOutput({tag, "_ifQueue"}, 32'(if_q.size()), 32'd1);
      else begin
        d = if_q.pop_front();
        checkOutput({tag, "_ifRdata"}, ifRdata, d);
      end
    end
    checkOutput({tag, "_lsRvalid"}, 32'(lsRvalid), 32'(exp_ls_valid));
    if (exp_ls_valid) begin
      if (ls_q.size() == 0) checkOutput({tag, "_lsQueue"}, 32'(ls_q.size()), 32'd1);
      else begin
        d = ls_q.pop_front();
        checkOutput({tag, "_lsRdata"}, lsRdata, d);
      end
    end
    checkOutput({tag, "_ifReady"}, 32'(ifReady), 32'(exp_if));
    checkOutput({tag, "_lsReady"}, 32'(lsReady), 32'(exp_ls));
    exp_if_valid = exp_if;
    exp_ls_valid = exp_ls && !lsWriteEn;
    if (exp_if) if_q.push_back(ref_mem[ifAddr]);
    if (exp_ls && !lsWriteEn) ls_q.push_back(ref_mem[lsAddr]);
    if (exp_ls && lsWriteEn) begin
      for (int b = 0; b < 4; b++) begin
        if (lsByteMask[b]) ref_mem[lsAddr][8*b +: 8] = lsWdata[8*b +: 8];
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_mem[a] = d;
    @(posedge clock);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    logic pattern [12];
    compared     = 0;
    mismatched   = 0;
    exp_if_valid = 1'b0;
    exp_ls_valid = 1'b0;
    pre_we       = 1'b0;
    pre_addr     = '0;
    pre_data     = '0;
    reset        = 1'b1;
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);

    preload(12'h010, 32'h0000_0013);
    preload(12'h020, 32'h1234_5678);
    preload(12'h001, 32'h0000_00A1);
    preload(12'h002, 32'h0000_00B2);

    // Both requesting while reset is held: nothing may be granted.
    applyStimulus(1'b1, 12'h010, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF);
    #1;
    checkOutput("rst_ifReady", 32'(ifReady), 32'd0);
    checkOutput("rst_lsReady", 32'(lsReady), 32'd0);
    checkOutput("rst_memWriteEn", 32'(memWriteEn), 32'd0);
    checkOutput("rst_memAddr", 32'(memAddr), 32'd0);
    checkOutput("rst_ifRvalid", 32'(ifRvalid), 32'd0);
    checkOutput("rst_lsRvalid", 32'(lsRvalid), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Release: ls wins first, then fetch.
    applyStimulus(1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
    runCycle("rel0", 1'b0, 1'b1);
    applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h020, 32'h0, 4'h0);
    runCycle("rel1", 1'b1, 1'b0);

    // Idle with busy-looking ls inputs: SRAM port must stay quiet.
    applyStimulus(1'b0, 12'h010, 1'b0, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'hF);
    #1;
    checkOutput("idle_memAddr", 32'(memAddr), 32'd0);
    checkOutput("idle_memWdata", memWdata, 32'd0);
    checkOutput("idle_memWriteEn", 32'(memWriteEn), 32'd0);
    checkOutput("idle_memByteMask", 32'(memByteMask), 32'd0);
    runCycle("idle", 1'b0, 1'b0);

    // Fetch-only read.
    applyStimulus(1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #1;
    checkOutput("fetch_memAddr", 32'(memAddr), 32'h010);
    runCycle("fetch", 1'b1, 1'b0);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    runCycle("fetch_rsp", 1'b0, 1'b0);

    // Partial store then load-back of the merged word.
    applyStimulus(1'b0, 12'h000, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 4'b0011);
    #1;
    checkOutput("st_memWriteEn", 32'(memWriteEn), 32'd1);
    checkOutput("st_memByteMask", 32'(memByteMask), 32'h3);
    checkOutput("st_memAddr", 32'(memAddr), 32'h020);
    checkOutput("st_memWdata", memWdata, 32'hDEAD_BEEF);
    runCycle("store", 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
    runCycle("load", 1'b0, 1'b1);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    runCycle("load_rsp", 1'b0, 1'b0);
    checkOutput("merged_word", ref_mem[12'h020], 32'h1234_BEEF);

    // Sustained contention: fetch gets every fifth slot.
    pattern = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    applyStimulus(1'b1, 12'h001, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
    for (int k = 0; k < 12; k++) begin
      runCycle($sformatf("streak%0d", k), !pattern[k], pattern[k]);
    end
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    runCycle("streak_rsp", 1'b0, 1'b0);

    // Alternating single requesters, back to back.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) applyStimulus(1'b1, 12'h001, 1'b0, 1'b0, 12'h002, 32'h0, 4'h0);
      else            applyStimulus(1'b0, 12'h001, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
      runCycle($sformatf("alt%0d", k), (k % 2 == 0), (k % 2 != 0));
    end
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    runCycle("alt_rsp", 1'b0, 1'b0);

    // Build a streak of two, then reset while a third load is being granted.
    applyStimulus(1'b1, 12'h001, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
    runCycle("pre_rst0", 1'b0, 1'b1);
    runCycle("pre_rst1", 1'b0, 1'b1);
    @(negedge clock);
    checkOutput("midrst_lsRvalid_before", 32'(lsRvalid), 32'd1);
    checkOutput("midrst_lsRdata_before", lsRdata, ls_q.pop_front());
    checkOutput("midrst_lsReady_before", 32'(lsReady), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_ifReady", 32'(ifReady), 32'd0);
    checkOutput("midrst_lsReady", 32'(lsReady), 32'd0);
    checkOutput("midrst_memWriteEn", 32'(memWriteEn), 32'd0);
    checkOutput("midrst_lsRvalid", 32'(lsRvalid), 32'd0);
    checkOutput("midrst_ifRvalid", 32'(ifRvalid), 32'd0);
    if_q.delete();
    ls_q.delete();
    exp_if_valid = 1'b0;
    exp_ls_valid = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midrst_lsRvalid_n1", 32'(lsRvalid), 32'd0);
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("midrst_lsRvalid_n2", 32'(lsRvalid), 32'd0);
    checkOutput("midrst_ifRvalid_n2", 32'(ifRvalid), 32'd0);

    // A cleared streak shows up as a full run of four ls grants before fetch.
    applyStimulus(1'b1, 12'h001, 1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) begin
      runCycle($sformatf("post_rst%0d", k), (k == 4), (k != 4));
    end
    applyStimulus(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
    runCycle("post_rst_rsp", 1'b0, 1'b0);
    runCycle("final_idle", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
